// File: rtl/mock_sram_folded.sv
// mock_sram_folded: behavioural stand-in for a tall 1R1W predictor SRAM.
// Folds DEPTH logical entries onto FOLD_DEPTH physical rows by XOR-ing all
// FOLD_W-bit slices of the address. Each row keeps a valid bit and the full
// address of its last writer, so reads of a row that another address
// overwrote are flagged as aliases.
// Read port: R0_en is sampled at posedge clock. The result appears on
// R0_data/R0_alias one cycle later and is held while R0_en is low.
// Write port: W0_en and W0_mask are sampled at posedge clock. Masked lanes
// take W0_data. An all-zero mask is a no-op.
// Optional feature macro: MOCK_SRAM_BYPASS_EN. When it is defined, a read and
// a write to the same row in one cycle return write-first data. When it is
// not defined, such a read returns read-first data.
module mock_sram_folded #(
    parameter int DEPTH      = 128,
    parameter int WIDTH      = 40,
    parameter int FOLD_DEPTH = 16,
    parameter int MASK_GRAN  = WIDTH,
    parameter int CNT_W      = 16,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int LANES     = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_alias,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [LANES-1:0]  W0_mask,
    input  logic [WIDTH-1:0]  W0_data,
    output logic [CNT_W-1:0]  alias_cnt
);
    localparam int FOLD_W = $clog2(FOLD_DEPTH);
    localparam int NSL    = (ADDR_W + FOLD_W - 1) / FOLD_W;

    // Row index: XOR of every FOLD_W-bit address slice, with the top slice zero-padded.
    function automatic logic [FOLD_W-1:0] f_fold(input logic [ADDR_W-1:0] a);
        logic [NSL*FOLD_W-1:0] p;
        logic [FOLD_W-1:0]     r;
        p = '0;
        p[ADDR_W-1:0] = a;
        r = '0;
        for (int i = 0; i < NSL; i++) begin
            r = r ^ p[i*FOLD_W +: FOLD_W];
        end
        return r;
    endfunction

    logic [WIDTH-1:0]  r_mem [FOLD_DEPTH];
    logic [ADDR_W-1:0] r_tag [FOLD_DEPTH];
    logic [FOLD_DEPTH-1:0] r_valid;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_alias;
    logic [CNT_W-1:0]  r_cnt;

    logic [FOLD_W-1:0] w_rd_row;
    logic [FOLD_W-1:0] w_wr_row;
    logic              w_wr_any;
    logic [WIDTH-1:0]  w_bmask;
    logic [WIDTH-1:0]  w_arr;
    logic [WIDTH-1:0]  w_rd_data_nxt;
    logic              w_rd_alias_nxt;
    logic              w_rd_evt;
    logic              w_wr_evt;
    logic [CNT_W:0]    w_cnt_sum;

    // Address folding, lane mask expansion, read result and alias events.
    always_comb begin
        w_rd_row = f_fold(R0_addr);
        w_wr_row = f_fold(W0_addr);
        w_wr_any = W0_en && (|W0_mask);
        w_bmask  = '0;
        for (int l = 0; l < LANES; l++) begin
            w_bmask[l*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[l]}};
        end
        w_arr = r_valid[w_rd_row] ? r_mem[w_rd_row] : '0;
`ifdef MOCK_SRAM_BYPASS_EN
        if (w_wr_any && (w_wr_row == w_rd_row)) begin
            // Write-first: the incoming write defines the row's new contents and tag.
            w_rd_data_nxt  = (W0_data & w_bmask) | (w_arr & ~w_bmask);
            w_rd_alias_nxt = (W0_addr != R0_addr);
        end else begin
            w_rd_data_nxt  = w_arr;
            w_rd_alias_nxt = r_valid[w_rd_row] && (r_tag[w_rd_row] != R0_addr);
        end
`else
        // Read-first: pre-write state decides both data and alias.
        w_rd_data_nxt  = w_arr;
        w_rd_alias_nxt = r_valid[w_rd_row] && (r_tag[w_rd_row] != R0_addr);
`endif
        w_rd_evt  = R0_en && w_rd_alias_nxt;
        w_wr_evt  = w_wr_any && r_valid[w_wr_row] && (r_tag[w_wr_row] != W0_addr);
        w_cnt_sum = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_rd_evt} + {{CNT_W{1'b0}}, w_wr_evt};
    end

    // Data and tag arrays are not reset. The valid bits hide stale contents.
    always_ff @(posedge clock) begin
        if (w_wr_any) begin
            for (int l = 0; l < LANES; l++) begin
                if (W0_mask[l]) begin
                    r_mem[w_wr_row][l*MASK_GRAN +: MASK_GRAN] <= W0_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
            r_tag[w_wr_row] <= W0_addr;
        end
    end

    // Valid bits, registered read outputs and the saturating alias counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= '0;
            r_rd_data  <= '0;
            r_rd_alias <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_wr_any) begin
                r_valid[w_wr_row] <= 1'b1;
            end
            if (R0_en) begin
                r_rd_data  <= w_rd_data_nxt;
                r_rd_alias <= w_rd_alias_nxt;
            end
            r_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
        end
    end

    assign R0_data   = r_rd_data;
    assign R0_alias  = r_rd_alias;
    assign alias_cnt = r_cnt;

endmodule
